// File: rtl/imem_sync_loadable.sv
// Synchronous instruction memory with a registered fetch port (stall/flush aware)
// and a byte-serial bootloader that assembles big-endian words into the array.
module imem_sync_loadable #(
    parameter int          ADDR_W   = 8,
    parameter int          DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic              stall,
    input  logic              flush,
    output logic [31:0]       instruction,
    output logic              inst_valid,
    output logic              addr_error,
    input  logic              load_en,
    input  logic              load_byte_valid,
    input  logic [7:0]        load_byte,
    output logic [ADDR_W:0]   load_count,
    output logic              load_full
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } ld_state_e;

    localparam logic [28:0]     DEPTH_W   = 29'(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

    logic [31:0]       mem_r [DEPTH];
    ld_state_e         state_r;
    logic [1:0]        byte_idx_r;
    logic [31:0]       asm_r;
    logic [ADDR_W:0]   load_count_r;
    logic              load_full_r;

    logic [ADDR_W-1:0] fetch_idx_s;
    logic [31:0]       asm_next_s;
    logic              fetch_fault_s;
    logic              wr_en_s;
    logic              unused_kernel_s;

    // The kernel bit plays no part in addressing.
    assign unused_kernel_s = pc[31];
    assign fetch_idx_s     = pc[ADDR_W+1:2];
    assign asm_next_s      = {asm_r[23:0], load_byte};
    assign load_count      = load_count_r;
    assign load_full       = load_full_r;

    // Fetch fault detection and array write enable.
    always_comb begin
        fetch_fault_s = 1'b0;
        wr_en_s       = 1'b0;
        if ((pc[1:0] != 2'b00) || (pc[30:2] >= DEPTH_W)) begin
            fetch_fault_s = 1'b1;
        end else begin
            fetch_fault_s = 1'b0;
        end
        // A word is committed only while the loader is still enabled and not being reset.
        if (!reset && load_en && (state_r == WRITE)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Program array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[load_count_r[ADDR_W-1:0]] <= asm_r;
        end
    end

    // Registered fetch port: reset > flush > stall > load mode > normal.
    always_ff @(posedge clk) begin
        if (reset) begin
            instruction <= NOP_WORD;
            inst_valid  <= 1'b0;
            addr_error  <= 1'b0;
        end else if (flush) begin
            instruction <= NOP_WORD;
            inst_valid  <= 1'b0;
            addr_error  <= 1'b0;
        end else if (stall) begin
            instruction <= instruction;
            inst_valid  <= inst_valid;
            addr_error  <= addr_error;
        end else if (load_en) begin
            instruction <= NOP_WORD;
            inst_valid  <= 1'b0;
            addr_error  <= 1'b0;
        end else if (fetch_fault_s) begin
            instruction <= NOP_WORD;
            inst_valid  <= 1'b1;
            addr_error  <= 1'b1;
        end else begin
            instruction <= mem_r[fetch_idx_s];
            inst_valid  <= 1'b1;
            addr_error  <= 1'b0;
        end
    end

    // Bootloader FSM: assembles four bytes per word, then spends one cycle writing it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            byte_idx_r   <= 2'd0;
            asm_r        <= 32'h0000_0000;
            load_count_r <= '0;
            load_full_r  <= 1'b0;
        end else if (!load_en) begin
            // Count and full flag stay visible until the next load session starts.
            state_r      <= IDLE;
            byte_idx_r   <= 2'd0;
            asm_r        <= asm_r;
            load_count_r <= load_count_r;
            load_full_r  <= load_full_r;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r      <= COLLECT;
                    byte_idx_r   <= 2'd0;
                    asm_r        <= asm_r;
                    load_count_r <= '0;
                    load_full_r  <= 1'b0;
                end
                COLLECT: begin
                    load_count_r <= load_count_r;
                    load_full_r  <= load_full_r;
                    if (load_byte_valid && !load_full_r) begin
                        asm_r <= asm_next_s;
                        if (byte_idx_r == 2'd3) begin
                            state_r    <= WRITE;
                            byte_idx_r <= 2'd0;
                        end else begin
                            state_r    <= COLLECT;
                            byte_idx_r <= byte_idx_r + 2'd1;
                        end
                    end else begin
                        state_r    <= COLLECT;
                        byte_idx_r <= byte_idx_r;
                        asm_r      <= asm_r;
                    end
                end
                WRITE: begin
                    state_r      <= COLLECT;
                    load_count_r <= load_count_r + CNT_ONE;
                    load_full_r  <= ((load_count_r + CNT_ONE) == DEPTH_CNT);
                    // A strobe arriving on the write cycle becomes byte 0 of the next word.
                    if (load_byte_valid) begin
                        asm_r      <= asm_next_s;
                        byte_idx_r <= 2'd1;
                    end else begin
                        asm_r      <= asm_r;
                        byte_idx_r <= 2'd0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    byte_idx_r   <= 2'd0;
                    asm_r        <= asm_r;
                    load_count_r <= load_count_r;
                    load_full_r  <= load_full_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_sync_loadable.sv
// Self-checking bench for imem_sync_loadable: bootloader fill, table-driven fetch
// vectors through a scoreboard queue, and hand-written loader corner cases.
module tb_imem_sync_loadable;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       pc;
    logic              stall;
    logic              flush;
    logic [31:0]       instruction;
    logic              inst_valid;
    logic              addr_error;
    logic              load_en;
    logic              load_byte_valid;
    logic [7:0]        load_byte;
    logic [ADDR_W:0]   load_count;
    logic              load_full;

    imem_sync_loadable #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .pc(pc), .stall(stall), .flush(flush),
        .instruction(instruction), .inst_valid(inst_valid), .addr_error(addr_error),
        .load_en(load_en), .load_byte_valid(load_byte_valid), .load_byte(load_byte),
        .load_count(load_count), .load_full(load_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        v;
        logic        e;
        string       name;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic        st;
        logic        fl;
        logic        ld;
        logic [31:0] ei;
        logic        ev;
        logic        ee;
        string       name;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[15];
    logic [31:0] exp_mem[DEPTH];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // Called at a negedge: drive one fetch, push expectation, compare one edge later.
    task automatic fetch(input logic [31:0] p, input logic st, input logic fl, input logic ld,
                         input logic [31:0] ei, input logic ev, input logic ee, input string nm);
        exp_t it;
        pc = p; stall = st; flush = fl; load_en = ld;
        it.instr = ei; it.v = ev; it.e = ee; it.name = nm;
        sb_q.push_back(it);
        @(negedge clk);
        it = sb_q.pop_front();
        chk({it.name, "_instr"}, instruction, it.instr);
        chk({it.name, "_valid"}, {31'd0, inst_valid}, {31'd0, it.v});
        chk({it.name, "_err"}, {31'd0, addr_error}, {31'd0, it.e});
    endtask

    // Called at a negedge: strobe one byte for a single cycle.
    task automatic send_byte(input logic [7:0] b);
        load_byte_valid = 1'b1;
        load_byte = b;
        @(negedge clk);
        load_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pc = 32'd0; stall = 1'b0; flush = 1'b0;
        load_en = 1'b0; load_byte_valid = 1'b0; load_byte = 8'd0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] b;
            b = 8'(i);
            exp_mem[i] = {b ^ 8'h5A, ~b, 8'hC3, b};
        end
        exp_mem[16] = 32'h0C00_000F;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_instr", instruction, NOP);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_err", {31'd0, addr_error}, 32'd0);
        chk("rst_count", {23'd0, load_count}, 32'd0);
        chk("rst_full", {31'd0, load_full}, 32'd0);

        // Fill the whole array back-to-back, then four surplus bytes.
        load_en = 1'b1;
        @(negedge clk);
        for (int w = 0; w < DEPTH; w++) send_word(exp_mem[w]);
        send_word(32'hDEAD_BEEF);
        repeat (2) @(negedge clk);
        chk("fill_count", {23'd0, load_count}, 32'd256);
        chk("fill_full", {31'd0, load_full}, 32'd1);
        chk("fill_load_instr", instruction, NOP);
        load_en = 1'b0;
        @(negedge clk);
        chk("hold_count", {23'd0, load_count}, 32'd256);
        chk("hold_full", {31'd0, load_full}, 32'd1);

        vecs[0]  = '{32'h0000_0040, 1'b0, 1'b0, 1'b0, exp_mem[16],  1'b1, 1'b0, "pc40"};
        vecs[1]  = '{32'h8000_0040, 1'b0, 1'b0, 1'b0, exp_mem[16],  1'b1, 1'b0, "kernel40"};
        vecs[2]  = '{32'h0000_0042, 1'b0, 1'b0, 1'b0, NOP,          1'b1, 1'b1, "misalign"};
        vecs[3]  = '{32'h0000_0400, 1'b0, 1'b0, 1'b0, NOP,          1'b1, 1'b1, "beyond"};
        vecs[4]  = '{32'h0000_03FC, 1'b0, 1'b0, 1'b0, exp_mem[255], 1'b1, 1'b0, "last"};
        vecs[5]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, exp_mem[0],   1'b1, 1'b0, "first"};
        vecs[6]  = '{32'h0000_0044, 1'b0, 1'b0, 1'b0, exp_mem[17],  1'b1, 1'b0, "pc44"};
        vecs[7]  = '{32'h0000_0048, 1'b1, 1'b0, 1'b0, exp_mem[17],  1'b1, 1'b0, "stall1"};
        vecs[8]  = '{32'h0000_004C, 1'b1, 1'b0, 1'b0, exp_mem[17],  1'b1, 1'b0, "stall2"};
        vecs[9]  = '{32'h0000_0042, 1'b1, 1'b0, 1'b0, exp_mem[17],  1'b1, 1'b0, "stall3"};
        vecs[10] = '{32'h0000_0050, 1'b1, 1'b1, 1'b0, NOP,          1'b0, 1'b0, "flush_stall"};
        vecs[11] = '{32'h0000_0042, 1'b0, 1'b0, 1'b0, NOP,          1'b1, 1'b1, "fault2"};
        vecs[12] = '{32'h0000_0040, 1'b1, 1'b0, 1'b0, NOP,          1'b1, 1'b1, "stall_fault"};
        vecs[13] = '{32'h0000_0040, 1'b0, 1'b0, 1'b1, NOP,          1'b0, 1'b0, "load_mode"};
        vecs[14] = '{32'h0000_0008, 1'b0, 1'b0, 1'b0, exp_mem[2],   1'b1, 1'b0, "pc8"};
        for (int i = 0; i < 15; i++) begin
            fetch(vecs[i].pc, vecs[i].st, vecs[i].fl, vecs[i].ld,
                  vecs[i].ei, vecs[i].ev, vecs[i].ee, vecs[i].name);
        end
        stall = 1'b0; flush = 1'b0;

        // Two words with gaps; byte AD lands on the write cycle of the first word.
        load_en = 1'b1;
        @(negedge clk);
        send_byte(8'h3C); @(negedge clk);
        send_byte(8'h0D); @(negedge clk);
        send_byte(8'h40); @(negedge clk);
        send_byte(8'h00);
        send_byte(8'hAD); @(negedge clk);
        send_byte(8'hA0); @(negedge clk);
        send_byte(8'h00); @(negedge clk);
        send_byte(8'h08); @(negedge clk);
        chk("seqA_count", {23'd0, load_count}, 32'd2);
        chk("seqA_full", {31'd0, load_full}, 32'd0);
        load_en = 1'b0;
        @(negedge clk);
        exp_mem[0] = 32'h3C0D_4000;
        exp_mem[1] = 32'hADA0_0008;
        fetch(32'h0, 1'b0, 1'b0, 1'b0, exp_mem[0], 1'b1, 1'b0, "seqA_w0");
        fetch(32'h4, 1'b0, 1'b0, 1'b0, exp_mem[1], 1'b1, 1'b0, "seqA_w1");
        fetch(32'h8, 1'b0, 1'b0, 1'b0, exp_mem[2], 1'b1, 1'b0, "seqA_w2");

        // Partial word abandoned by dropping load_en, then a fresh session.
        load_en = 1'b1;
        @(negedge clk);
        send_byte(8'h11);
        send_byte(8'h22);
        load_en = 1'b0;
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        send_word(32'h5566_7788);
        @(negedge clk);
        chk("seqB_count", {23'd0, load_count}, 32'd1);
        load_en = 1'b0;
        @(negedge clk);
        exp_mem[0] = 32'h5566_7788;
        fetch(32'h0, 1'b0, 1'b0, 1'b0, exp_mem[0], 1'b1, 1'b0, "seqB_w0");
        fetch(32'h4, 1'b0, 1'b0, 1'b0, exp_mem[1], 1'b1, 1'b0, "seqB_w1");

        // Reset mid-word, then reset on the write cycle.
        load_en = 1'b1;
        @(negedge clk);
        send_byte(8'h01);
        send_byte(8'h02);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_count", {23'd0, load_count}, 32'd0);
        chk("rstmid_instr", instruction, NOP);
        chk("rstmid_valid", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        send_word(32'hCAFE_F00D);
        @(negedge clk);
        chk("rstmid_after_count", {23'd0, load_count}, 32'd1);
        send_word(32'h1112_1314);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        load_en = 1'b0;
        chk("rstwr_count", {23'd0, load_count}, 32'd0);
        @(negedge clk);
        exp_mem[0] = 32'hCAFE_F00D;
        fetch(32'h0, 1'b0, 1'b0, 1'b0, exp_mem[0], 1'b1, 1'b0, "rst_w0");
        fetch(32'h4, 1'b0, 1'b0, 1'b0, exp_mem[1], 1'b1, 1'b0, "rst_w1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_sync_loadable.md
Name: imem_sync_loadable

Overview:
Parametrised synchronous instruction memory for the pipelined MIPS core; successor to the single-cycle combinational instruction ROM. Word array with a 1-cycle registered fetch port that supports pipeline stall and flush. A byte-serial bootloader port, fed by the UART receiver, writes program words at runtime so programs are no longer hard-coded. Sits between the IF-stage PC register and the IF/ID pipeline register.

Parameters:
ADDR_W, 8, word-address bits; array index = pc[ADDR_W+1:2]
DEPTH, 256, number of 32-bit words implemented; must be <= 2**ADDR_W
NOP_WORD, 32'h00000000, word driven on flush, reset, load mode, and fault

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
pc  in  32  byte fetch address; bit 31 is the kernel/supervisor bit, ignored for indexing
stall  in  1  hold fetch outputs unchanged
flush  in  1  replace the next fetched word with NOP_WORD
instruction  out  32  registered fetched word
inst_valid  out  1  instruction holds a real fetched word
addr_error  out  1  registered fetch fault: pc[1:0]!=0, or pc[30:2] >= DEPTH
load_en  in  1  loader mode: fetch is suppressed and the byte stream is accepted
load_byte_valid  in  1  one-cycle strobe; load_byte is valid
load_byte  in  8  program byte, big-endian within each word
load_count  out  ADDR_W+1  words written since load_en rose
load_full  out  1  load_count == DEPTH; further bytes are dropped

Behaviour:
- One clock; reset is synchronous and active-high. The clock port is named clk and the reset port is named reset.
- Reset: instruction=NOP_WORD, inst_valid=0, addr_error=0, load_count=0, load_full=0, loader FSM=IDLE, byte index=0. The memory array is not cleared.
- Fetch priority per edge, highest first: reset > flush > stall > load_en > normal.
  - flush: instruction=NOP_WORD, inst_valid=0, addr_error=0. Flush wins over stall when both are asserted.
  - stall: instruction, inst_valid and addr_error all hold.
  - load_en=1: instruction=NOP_WORD, inst_valid=0, addr_error=0.
  - normal, good address: instruction=mem[pc[ADDR_W+1:2]] on the next edge (latency 1), inst_valid=1, addr_error=0.
  - normal, fault: instruction=NOP_WORD, inst_valid=1, addr_error=1.
- Kernel bit: pc 0x80000040 and 0x00000040 fetch the same word.
- Loader FSM states: IDLE, COLLECT, WRITE.
  - IDLE -> COLLECT on a load_en rising edge. On that edge load_count=0, byte index=0, load_full=0.
  - COLLECT: each load_byte_valid shifts the byte into a 32-bit assembly register, first byte at [31:24]. On the 4th byte go to WRITE.
  - WRITE (one cycle): mem[load_count]<=assembled word, load_count++, load_full set if the new count == DEPTH, then return to COLLECT.
  - A byte strobe during WRITE is captured as byte 0 of the next word; no byte is lost.
  - When load_full=1, strobes are ignored and no write occurs.
  - load_en falling in any state -> IDLE. A partially assembled word is discarded. load_count and load_full hold their values until the next rising edge of load_en.
  - load_byte_valid while load_en=0 is ignored.
- Reset during COLLECT or WRITE: go to IDLE with no write that cycle. Words already written stay in the array.
- Read-during-write is not possible, because fetch is suppressed while load_en=1.

Test Plan:
- Reset, then preload mem[16]=0x0C00000F, set pc=0x40 -> instruction=0x0C00000F and inst_valid=1 one edge later; pc=0x80000040 gives the same word.
- Fetch pc=0x42 -> NOP_WORD, addr_error=1. Fetch pc=DEPTH*4=0x400 -> NOP_WORD, addr_error=1. Fetch pc=0x3FC -> mem[255], addr_error=0.
- Fetch pc=0x44, then stall=1 for 3 cycles while pc changes -> instruction holds mem[17]. Assert flush+stall together -> NOP_WORD, inst_valid=0.
- load_en=1, send bytes 3C,0D,40,00,AD,A0,00,08 with gaps, one byte back-to-back on the WRITE cycle -> mem[0]=0x3C0D4000, mem[1]=0xADA00008, load_count=2. Drop load_en, fetch pc=0 -> 0x3C0D4000.
- Send 2 bytes then drop load_en, raise it again and send 4 bytes -> only mem[0] is written with the new word, load_count=1.
- Stream DEPTH*4+4 bytes -> load_full=1 at count 256; the extra 4 bytes leave mem unchanged; reset mid-word -> no write and FSM is IDLE.
